// File: rtl/aes_key_schedule.sv
// AES-128 key-schedule controller: accepts a cipher key, expands one round key per clock,
// and serves the 11 round keys through a registered read port.
module aes_key_schedule #(
    parameter int NR    = 10,
    parameter int KEY_W = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [KEY_W-1:0] key,
    output logic             busy,
    output logic             keys_ready,
    input  logic [3:0]       rk_addr,
    output logic [KEY_W-1:0] rk_data
);

    // state  | meaning
    // IDLE   | no key loaded since reset, accepting a key
    // EXPAND | one round key generated per clock, rc = 0..NR-1
    // DONE   | all NR+1 round keys valid, accepting a new key
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic [3:0]       rc;
    logic [KEY_W-1:0] cur_key;
    logic [KEY_W-1:0] next_key;
    logic [KEY_W-1:0] rd_word;
    logic [KEY_W-1:0] rk [0:NR];

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254, which maps 0 to 0) followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd0:    v = 8'h01;
            4'd1:    v = 8'h02;
            4'd2:    v = 8'h04;
            4'd3:    v = 8'h08;
            4'd4:    v = 8'h10;
            4'd5:    v = 8'h20;
            4'd6:    v = 8'h40;
            4'd7:    v = 8'h80;
            4'd8:    v = 8'h1b;
            4'd9:    v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [KEY_W-1:0] key_expansion(input logic [KEY_W-1:0] k,
                                                       input logic [3:0]       r);
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
        logic [31:0] t;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        // RotWord then SubWord on the last word, with the round constant in the top byte
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
           ^ {rcon(r), 24'h000000};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    assign next_key = key_expansion(cur_key, rc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        load       = 1'b0;
        key_ready  = 1'b1;
        busy       = 1'b0;
        keys_ready = 1'b0;
        case (state)
            S_IDLE: begin
                if (key_valid) begin
                    load      = 1'b1;
                    state_nxt = S_EXPAND;
                end
            end
            S_EXPAND: begin
                key_ready = 1'b0;
                busy      = 1'b1;
                if (rc == 4'(NR - 1)) state_nxt = S_DONE;
            end
            S_DONE: begin
                keys_ready = 1'b1;
                if (key_valid) begin
                    load      = 1'b1;
                    state_nxt = S_EXPAND;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i <= NR; i++) begin
            if (rk_addr == 4'(i)) rd_word = rk[i];
        end
    end

    // Reads see the register contents before this edge's write (no write-through)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rc      <= '0;
            cur_key <= '0;
            rk_data <= '0;
            for (int i = 0; i <= NR; i++) rk[i] <= '0;
        end else begin
            rk_data <= rd_word;
            if (load) begin
                rk[0]   <= key;
                cur_key <= key;
                rc      <= '0;
            end else if (state == S_EXPAND) begin
                cur_key <= next_key;
                rc      <= rc + 4'd1;
                for (int i = 1; i <= NR; i++) begin
                    if (rc == 4'(i - 1)) rk[i] <= next_key;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Scoreboard bench for aes_key_schedule: a word-level FIPS-197 key-expansion model feeds
// expected round keys into a queue that a read monitor drains one cycle after each address.
module tb_aes_key_schedule;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         key_valid = 1'b0;
    logic [127:0] key       = '0;
    logic [3:0]   rk_addr   = '0;
    logic         key_ready;
    logic         busy;
    logic         keys_ready;
    logic [127:0] rk_data;

    always #5 clk = ~clk;

    aes_key_schedule dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key        (key),
        .busy       (busy),
        .keys_ready (keys_ready),
        .rk_addr    (rk_addr),
        .rk_data    (rk_data)
    );

    int           n_pass  = 0;
    int           n_total = 0;
    logic [7:0]   sbox_ref [256];
    logic [127:0] exp_rk [11];
    logic [127:0] exp_q [$];
    string        name_q [$];
    bit           rd_req  = 1'b0;
    bit           rd_pend = 1'b0;

    localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K1_RKA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K0_RK1 = 128'h62636363626363636263636362636363;
    localparam logic [127:0] K0_RKA = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, req);
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box built by walking generator 3 and its inverse, no field inversion needed
    task automatic init_sbox();
        logic [7:0] p;
        logic [7:0] q;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            sbox_ref[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
        end while (p != 8'h01);
        sbox_ref[0] = 8'h63;
    endtask

    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc_byte;
        rc_byte = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]};
                t[31:24] = t[31:24] ^ rc_byte;
                rc_byte = {rc_byte[6:0], 1'b0} ^ (rc_byte[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    task automatic issue_read(input logic [3:0] a, input logic [127:0] e, input string nm);
        rk_addr = a;
        rd_req  = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        rd_req = 1'b0;
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 16; a++) begin
            issue_read(4'(a), (a <= 10) ? exp_rk[a] : 128'h0, $sformatf("%s_rk%0d", tag, a));
        end
    endtask

    task automatic load_key(input logic [127:0] k, input bit hold);
        int n;
        check("key_ready_before_load", key_ready, 1'b1);
        key       = k;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        if (hold) key = {$urandom, $urandom, $urandom, $urandom};
        else      key_valid = 1'b0;
        check("busy_after_accept", busy, 1'b1);
        check("key_ready_in_expand", key_ready, 1'b0);
        check("keys_ready_after_accept", keys_ready, 1'b0);
        n = 0;
        while (!keys_ready && n < 30) begin
            if (hold) check("key_ready_held_valid", key_ready, 1'b0);
            @(posedge clk);
            #1;
            n++;
        end
        key_valid = 1'b0;
        // accept cycle plus ten expansion cycles: keys_ready shows after the 10th later edge
        check("keys_ready_latency", 128'(n), 128'd10);
        check("keys_ready_done", keys_ready, 1'b1);
        check("busy_done", busy, 1'b0);
        model_expand(k);
    endtask

    always @(posedge clk) rd_pend <= rd_req;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL read_underflow: got read data %h, expected no pending read", rk_data);
            end else begin
                check(name_q.pop_front(), rk_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected run to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] rk_rand;
        int           n;
        init_sbox();

        #12;
        check("reset_key_ready", key_ready, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_keys_ready", keys_ready, 1'b0);
        check("reset_rk_data", rk_data, 128'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        load_key(K1, 1'b0);
        sweep("k1");
        issue_read(4'd1, K1_RK1, "k1_vec_rk1");
        issue_read(4'd10, K1_RKA, "k1_vec_rk10");

        load_key(K1, 1'b1);
        sweep("k1_hold");
        issue_read(4'd10, K1_RKA, "k1_hold_vec_rk10");

        check("done_keys_ready", keys_ready, 1'b1);
        load_key(128'h0, 1'b0);
        sweep("k0");
        issue_read(4'd0, 128'h0, "k0_vec_rk0");
        issue_read(4'd1, K0_RK1, "k0_vec_rk1");
        issue_read(4'd10, K0_RKA, "k0_vec_rk10");

        for (int r = 0; r < 4; r++) begin
            rk_rand = {$urandom, $urandom, $urandom, $urandom};
            load_key(rk_rand, 1'b0);
            sweep($sformatf("rand%0d", r));
        end

        rk_rand   = {$urandom, $urandom, $urandom, $urandom};
        key       = rk_rand;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_key_ready", key_ready, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_keys_ready", keys_ready, 1'b0);
        check("midrst_rk_data", rk_data, 128'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int r = 0; r < 11; r++) exp_rk[r] = '0;
        sweep("cleared");
        check("cleared_keys_ready", keys_ready, 1'b0);

        rk_rand = {$urandom, $urandom, $urandom, $urandom};
        load_key(rk_rand, 1'b0);
        sweep("after_rst");

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
